// File: rtl/bpred_pkg.sv
// Shared defaults, FSM state encoding and pending-update entry layout for the
// perceptron training controller.
package bpred_pkg;

  localparam int GHR_SIZE_DEF   = 12;
  localparam int IDX_W_DEF      = 6;
  localparam int WEIGHT_W_DEF   = 8;
  localparam int THETA_DEF      = 14;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4
  } upd_state_t;

  typedef struct packed {
    logic [IDX_W_DEF-1:0]    idx;
    logic                    dir;
    logic [GHR_SIZE_DEF-1:0] ghr;
  } upd_entry_t;

endpackage

// File: rtl/bpred_upd_fifo.sv
// Synchronous queue of pending perceptron updates; a push while full is
// refused even when a pop happens in the same cycle.
module bpred_upd_fifo
  import bpred_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  upd_entry_t din,
  input  logic       pop,
  output upd_entry_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  upd_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == CNT_ZERO);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_q[rptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok_s) begin
      wptr_d = (wptr_q == LAST_PTR) ? PTR_ZERO : wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_ok_s) begin
      rptr_d = (rptr_q == LAST_PTR) ? PTR_ZERO : rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= PTR_ZERO;
      rptr_q <= PTR_ZERO;
      cnt_q  <= CNT_ZERO;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wptr_q] <= din;
    end
  end

endmodule

// File: rtl/perceptron_update_ctrl.sv
// Perceptron weight-table training controller: zero-fills the table after reset,
// then serialises queued updates as read-modify-write sequences.
// Build option BPRED_TRAIN_THRESH_EN also trains correct predictions with |sum| <= THETA.
module perceptron_update_ctrl
  import bpred_pkg::*;
#(
  parameter int GHR_SIZE   = GHR_SIZE_DEF,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int WEIGHT_W   = WEIGHT_W_DEF,
  parameter int THETA      = THETA_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         up_valid,
  output logic                         up_ready,
  input  logic [31:0]                  up_pc,
  input  logic                         up_dir,
  input  logic [GHR_SIZE-1:0]          up_ghr,
  input  logic signed [WEIGHT_W-1:0]   up_sum,
  input  logic                         up_miss,
  input  logic                         stall,
  output logic [IDX_W-1:0]             tbl_raddr,
  input  logic [GHR_SIZE*WEIGHT_W-1:0] tbl_rdata,
  output logic [IDX_W-1:0]             tbl_waddr,
  output logic [GHR_SIZE*WEIGHT_W-1:0] tbl_wdata,
  output logic                         tbl_wen,
  output logic                         init_busy,
  output logic [31:0]                  upd_count
);

  localparam int ROW_W = GHR_SIZE * WEIGHT_W;
  localparam logic [IDX_W-1:0]           IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]           IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]           LAST_IDX = {IDX_W{1'b1}};
  localparam logic [ROW_W-1:0]           ROW_ZERO = {ROW_W{1'b0}};
  localparam logic signed [WEIGHT_W-1:0] W_MAX    = {1'b0, {(WEIGHT_W - 1){1'b1}}};
  localparam logic signed [WEIGHT_W-1:0] W_MIN    = {1'b1, {(WEIGHT_W - 1){1'b0}}};
  localparam logic signed [WEIGHT_W-1:0] W_ONE    = WEIGHT_W'(1);
  localparam logic signed [WEIGHT_W:0]   THETA_S  = (WEIGHT_W + 1)'(THETA);

  // Agreement between outcome and history bit pushes a weight up, else down; saturating.
  function automatic logic [ROW_W-1:0] train_row(input logic [ROW_W-1:0]    row,
                                                 input logic                dir,
                                                 input logic [GHR_SIZE-1:0] ghr);
    logic signed [WEIGHT_W-1:0] w;
    logic [ROW_W-1:0]           res;
    res = row;
    for (int i = 0; i < GHR_SIZE; i++) begin
      w = row[i*WEIGHT_W +: WEIGHT_W];
      if (dir == ghr[i]) begin
        if (w != W_MAX) w = w + W_ONE;
      end else begin
        if (w != W_MIN) w = w - W_ONE;
      end
      res[i*WEIGHT_W +: WEIGHT_W] = w;
    end
    return res;
  endfunction

  upd_state_t       state_q;
  logic             wen_q;
  logic [IDX_W-1:0] raddr_q;
  logic [IDX_W-1:0] waddr_q;
  logic [ROW_W-1:0] wdata_q;
  logic [31:0]      cnt_q;

  upd_entry_t push_entry_s;
  upd_entry_t head_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic       push_s;
  logic       pop_s;
  logic       train_s;
  logic       unused_s;

`ifdef BPRED_TRAIN_THRESH_EN
  logic signed [WEIGHT_W:0] sum_ext_s;
  logic signed [WEIGHT_W:0] sum_mag_s;

  // Low-confidence correct predictions also train; widened so |-2^(W-1)| fits
  always_comb begin
    sum_ext_s = (WEIGHT_W + 1)'(up_sum);
    if (sum_ext_s[WEIGHT_W]) begin
      sum_mag_s = -sum_ext_s;
    end else begin
      sum_mag_s = sum_ext_s;
    end
    train_s = up_miss | (sum_mag_s <= THETA_S);
  end

  assign unused_s = ^{up_pc[31:IDX_W+2], up_pc[1:0]};
`else
  assign train_s  = up_miss;
  assign unused_s = ^{up_pc[31:IDX_W+2], up_pc[1:0], up_sum, THETA_S};
`endif

  assign init_busy    = (state_q == ST_INIT);
  assign up_ready     = ~fifo_full_s & ~init_busy;
  assign push_s       = up_valid & up_ready & train_s;
  assign pop_s        = (state_q == ST_WRITE) & ~stall;
  assign push_entry_s = '{idx: up_pc[IDX_W+1:2], dir: up_dir, ghr: up_ghr};

  assign tbl_wen   = wen_q & ~stall;
  assign tbl_raddr = raddr_q;
  assign tbl_waddr = waddr_q;
  assign tbl_wdata = wdata_q;
  assign upd_count = cnt_q;

  bpred_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   (push_entry_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Sweep/RMW sequencer; waddr_q doubles as the init sweep index, and a stall freezes everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      wen_q   <= 1'b0;
      raddr_q <= IDX_ZERO;
      waddr_q <= IDX_ZERO;
      wdata_q <= ROW_ZERO;
      cnt_q   <= 32'd0;
    end else if (!stall) begin
      case (state_q)
        ST_INIT: begin
          wdata_q <= ROW_ZERO;
          if (!wen_q) begin
            wen_q <= 1'b1;
          end else if (waddr_q == LAST_IDX) begin
            wen_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            waddr_q <= waddr_q + IDX_ONE;
          end
        end
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            raddr_q <= head_s.idx;
            state_q <= ST_READ;
          end
        end
        ST_READ: state_q <= ST_WAIT;
        ST_WAIT: begin
          wdata_q <= train_row(tbl_rdata, head_s.dir, head_s.ghr);
          waddr_q <= head_s.idx;
          wen_q   <= 1'b1;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          wen_q   <= 1'b0;
          cnt_q   <= cnt_q + 32'd1;
          state_q <= ST_IDLE;
        end
        default: begin
          wen_q   <= 1'b0;
          waddr_q <= IDX_ZERO;
          wdata_q <= ROW_ZERO;
          state_q <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_update_ctrl.sv
// Directed bench for perceptron_update_ctrl with a behavioural one-cycle-latency
// table model and a write monitor.
module tb_perceptron_update_ctrl;

  localparam int ROW_W = 96;

  logic             clk = 1'b0;
  logic             reset;
  logic             up_valid;
  logic             up_ready;
  logic [31:0]      up_pc;
  logic             up_dir;
  logic [11:0]      up_ghr;
  logic [7:0]       up_sum;
  logic             up_miss;
  logic             stall;
  logic [5:0]       tbl_raddr;
  logic [ROW_W-1:0] tbl_rdata;
  logic [5:0]       tbl_waddr;
  logic [ROW_W-1:0] tbl_wdata;
  logic             tbl_wen;
  logic             init_busy;
  logic [31:0]      upd_count;

  logic [ROW_W-1:0] tmem [64];
  logic             pl_en;
  logic [5:0]       pl_addr;
  logic [ROW_W-1:0] pl_data;

  int cyc = 0;
  int init_n = 0;
  int init_first = 0;
  int init_last = 0;
  logic init_bad = 1'b0;
  int wr_n = 0;
  int last_wcyc = 0;
  logic [5:0]       last_waddr = 6'd0;
  logic [ROW_W-1:0] last_wdata = '0;

  int n_checks = 0;
  int n_fail = 0;
  int req_cyc = 0;
  int exp_wr = 0;

  perceptron_update_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_pc     (up_pc),
    .up_dir    (up_dir),
    .up_ghr    (up_ghr),
    .up_sum    (up_sum),
    .up_miss   (up_miss),
    .stall     (stall),
    .tbl_raddr (tbl_raddr),
    .tbl_rdata (tbl_rdata),
    .tbl_waddr (tbl_waddr),
    .tbl_wdata (tbl_wdata),
    .tbl_wen   (tbl_wen),
    .init_busy (init_busy),
    .upd_count (upd_count)
  );

  initial forever #5 clk = ~clk;

  // Table model plus write monitor
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    tbl_rdata <= tmem[tbl_raddr];
    if (pl_en) tmem[pl_addr] <= pl_data;
    if (tbl_wen) begin
      tmem[tbl_waddr] <= tbl_wdata;
      if (init_busy) begin
        if (tbl_waddr != 6'(init_n) || tbl_wdata != '0) init_bad <= 1'b1;
        if (init_n == 0) init_first <= cyc;
        init_last <= cyc;
        init_n    <= init_n + 1;
      end else begin
        wr_n       <= wr_n + 1;
        last_waddr <= tbl_waddr;
        last_wdata <= tbl_wdata;
        last_wcyc  <= cyc;
      end
    end
    if (reset) begin
      init_n   <= 0;
      init_bad <= 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] pc, input logic dir, input logic [11:0] ghr,
                      input logic [7:0] sum, input logic miss);
    up_valid = 1'b1; up_pc = pc; up_dir = dir; up_ghr = ghr; up_sum = sum; up_miss = miss;
    req_cyc = cyc;
    @(negedge clk);
    up_valid = 1'b0;
  endtask

  task automatic preload(input logic [5:0] addr, input logic [ROW_W-1:0] data);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_wr(input int target, input int budget);
    for (int i = 0; i < budget && wr_n < target; i++) @(negedge clk);
    check_val("wr_count", wr_n, target);
  endtask

  task automatic wait_init(input int budget);
    for (int i = 0; i < budget && init_busy; i++) @(negedge clk);
    check_val("init_done", init_busy, 1'b0);
    check_val("init_writes", init_n, 64);
    check_val("init_seq_zero", init_bad, 1'b0);
    check_val("init_consecutive", init_last - init_first, 63);
  endtask

  logic [7:0] sum_tab [7] = '{8'd20, 8'd10, 8'hF2, 8'hF1, 8'd14, 8'd15, 8'h80};
  bit         tr_tab  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       bb_dir  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [11:0] bb_ghr [5] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h00F, 12'hFFF};

  initial begin
    reset = 1'b1; up_valid = 1'b0; up_pc = 32'd0; up_dir = 1'b0; up_ghr = 12'd0;
    up_sum = 8'd0; up_miss = 1'b0; stall = 1'b0; pl_en = 1'b0; pl_addr = 6'd0; pl_data = '0;
    repeat (2) @(negedge clk);
    check_val("rst_wen", tbl_wen, 1'b0);
    check_val("rst_ready", up_ready, 1'b0);
    check_val("rst_busy", init_busy, 1'b1);
    check_val("rst_count", upd_count, 32'd0);
    check_val("rst_raddr", tbl_raddr, 6'd0);
    check_val("rst_waddr", tbl_waddr, 6'd0);
    check_val("rst_wdata", tbl_wdata, 96'd0);
    reset = 1'b0;
    wait_init(300);
    check_val("post_init_ready", up_ready, 1'b1);
    check_val("post_init_wen", tbl_wen, 1'b0);

    // Basic miss: row 0x10 all +5 -> all +6, write 3 cycles after head
    preload(6'h10, {12{8'h05}});
    send(32'h40, 1'b1, 12'hFFF, 8'd0, 1'b1);
    exp_wr++;
    wait_wr(exp_wr, 20);
    check_val("basic_waddr", last_waddr, 6'h10);
    check_val("basic_wdata", last_wdata, {12{8'h06}});
    check_val("basic_latency", last_wcyc - req_cyc, 4);
    check_val("basic_count", upd_count, 32'd1);

    // Saturation at both rails
    preload(6'h01, {12{8'h7F}});
    send(32'h04, 1'b1, 12'hFFF, 8'd0, 1'b1);
    exp_wr++;
    wait_wr(exp_wr, 20);
    check_val("sat_hi", last_wdata, {12{8'h7F}});
    preload(6'h02, {12{8'h80}});
    send(32'h08, 1'b1, 12'h000, 8'd0, 1'b1);
    exp_wr++;
    wait_wr(exp_wr, 20);
    check_val("sat_lo", last_wdata, {12{8'h80}});
    check_val("sat_lo_addr", last_waddr, 6'h02);

    // Correct predictions: trained only when build option set and |sum| <= 14
    for (int k = 0; k < 7; k++) begin
      send(32'h0C, 1'b1, 12'hFFF, sum_tab[k], 1'b0);
`ifdef BPRED_TRAIN_THRESH_EN
      if (tr_tab[k]) exp_wr++;
`endif
      repeat (8) @(negedge clk);
      check_val("thresh_writes", wr_n, exp_wr);
      check_val("thresh_count", upd_count, exp_wr);
    end

    // Five back-to-back misses to row 5; the fifth is refused while full
    for (int k = 0; k < 5; k++) begin
      up_valid = 1'b1; up_pc = 32'h14; up_dir = bb_dir[k]; up_ghr = bb_ghr[k];
      up_sum = 8'd0; up_miss = 1'b1;
      if (k == 3) check_val("bb_ready_4th", up_ready, 1'b1);
      if (k == 4) check_val("bb_ready_5th", up_ready, 1'b0);
      @(negedge clk);
    end
    up_valid = 1'b0;
    exp_wr += 4;
    wait_wr(exp_wr, 40);
    repeat (10) @(negedge clk);
    check_val("bb_no_fifth", wr_n, exp_wr);
    check_val("bb_addr", last_waddr, 6'h05);
    check_val("bb_row", last_wdata, 96'h0000_0000_0000_0000_0202_0202);
    check_val("bb_count", upd_count, exp_wr);

    // Stall three cycles in WAIT
    preload(6'h06, {12{8'h10}});
    send(32'h18, 1'b0, 12'h000, 8'd0, 1'b1);
    repeat (2) @(negedge clk);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    check_val("stall_wen", tbl_wen, 1'b0);
    check_val("stall_count", upd_count, exp_wr);
    @(negedge clk);
    stall = 1'b0;
    exp_wr++;
    wait_wr(exp_wr, 20);
    check_val("stall_data", last_wdata, {12{8'h11}});
    check_val("stall_latency", last_wcyc - req_cyc, 7);

    // Reset in the middle of READ restarts the sweep
    send(32'h1C, 1'b1, 12'hFFF, 8'd0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("rr_busy", init_busy, 1'b1);
    check_val("rr_ready", up_ready, 1'b0);
    check_val("rr_count", upd_count, 32'd0);
    check_val("rr_raddr", tbl_raddr, 6'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_init(300);
    check_val("rr_no_stale_wr", wr_n, exp_wr);

    // Reset during WRITE discards the pending write
    send(32'h20, 1'b1, 12'hFFF, 8'd0, 1'b1);
    repeat (3) @(negedge clk);
    check_val("rw_wen_before", tbl_wen, 1'b1);
    reset = 1'b1;
    #1;
    check_val("rw_wen_after", tbl_wen, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_init(300);
    check_val("rw_discarded", wr_n, exp_wr);
    check_val("rw_count", upd_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
